// File: rtl/ahb_pkg.sv
// Shared AHB types for the SRAM-port arbiter: transfer/burst encodings,
// arbiter FSM states and the fixed-burst length lookup.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB_IDLE,    // default master parked, nobody requesting
    ARB_OWNED,   // single transfers or undefined-length INCR
    ARB_BURST,   // fixed-length burst with beats remaining
    ARB_LOCKED   // locked sequence, owner keeps the bus
  } arb_state_t;

  // Wide enough for the 15 beats left after an accepted 16-beat NONSEQ.
  localparam int BEAT_CNT_W = 4;
  typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

  // Beats still to come after the NONSEQ of a burst; zero means the burst
  // has no fixed length and the bus may be handed over at any point.
  function automatic beat_cnt_t burst_beats_left(input hburst_t burst);
    beat_cnt_t beats;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = beat_cnt_t'(3);
      HBURST_WRAP8,  HBURST_INCR8:  beats = beat_cnt_t'(7);
      HBURST_WRAP16, HBURST_INCR16: beats = beat_cnt_t'(15);
      default:                      beats = '0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin selector: scans requests starting one past the
// pointer and wrapping, so the pointer's own master has the lowest priority.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] pick_onehot,
  output logic [IDX_W-1:0]       pick_idx,
  output logic                   pick_valid
);

  // First requester found walking ptr+1, ptr+2, ... ptr (wrapping).
  always_comb begin
    logic [IDX_W-1:0] cand;
    // NOTE: every output of a combinational block gets a default first so no
    // path through the loop can leave it unassigned and infer a latch.
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_MASTERS);
      if (!pick_valid && req[cand]) begin
        pick_valid        = 1'b1;
        pick_idx          = cand;
        pick_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Round-robin AHB arbiter for the shared SRAM slave port. Owns hgrant, the
// address- and data-phase owner indices and hmastlock; handover only happens
// on hready edges outside fixed bursts and locked sequences.
module ahb_sram_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int HMASTER_WIDTH  = 8,
  parameter int HBURST_WIDTH   = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NUM_MASTERS-1:0]   hbusreq,
  input  logic [NUM_MASTERS-1:0]   hlock,
  input  logic [1:0]               htrans,
  input  logic [HBURST_WIDTH-1:0]  hburst,
  input  logic                     hready,
  output logic [NUM_MASTERS-1:0]   hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic [HMASTER_WIDTH-1:0] hmaster_data,
  output logic                     hmastlock
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t             state_q, state_d;
  beat_cnt_t              cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [IDX_W-1:0]       hmaster_q, hmaster_d;
  logic [IDX_W-1:0]       hmaster_data_q, hmaster_data_d;
  logic                   hmastlock_q, hmastlock_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  htrans_t   trans;
  beat_cnt_t burst_len;
  logic      owner_locked;

  assign trans        = htrans_t'(htrans);
  assign burst_len    = burst_beats_left(hburst_t'(hburst[2:0]));
  assign owner_locked = hlock[hmaster_q];

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req         (hbusreq),
    .ptr         (ptr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  // Next-state, burst counting and grant selection; everything holds while
  // hready is low.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    hgrant_d       = hgrant_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hmastlock_d    = hmastlock_q;

    if (hready) begin
      // The address phase just accepted becomes the data phase.
      hmaster_data_d = hmaster_q;

      unique case (state_q)
        ARB_IDLE, ARB_OWNED: begin
          if (trans == HTRANS_NONSEQ && burst_len != '0) begin
            // Owner starts a fixed burst: freeze the grant for its beats.
            cnt_d   = burst_len;
            state_d = ARB_BURST;
          end else if (owner_locked) begin
            // Lock owner always wins while it holds hlock.
            ptr_d       = hmaster_q;
            hmastlock_d = 1'b1;
            state_d     = ARB_LOCKED;
          end else if (pick_valid) begin
            ptr_d       = pick_idx;
            hgrant_d    = pick_onehot;
            hmaster_d   = pick_idx;
            hmastlock_d = hlock[pick_idx];
            state_d     = ARB_OWNED;
          end else begin
            // Nobody asking: park on the default master.
            hgrant_d    = DEF_GRANT;
            hmaster_d   = DEF_IDX;
            hmastlock_d = hlock[DEF_IDX];
            state_d     = ARB_IDLE;
          end
        end

        ARB_BURST, ARB_LOCKED: begin
          unique case (trans)
            HTRANS_SEQ:    if (cnt_q != '0) cnt_d = cnt_q - beat_cnt_t'(1);
            HTRANS_BUSY:   cnt_d = cnt_q;
            HTRANS_NONSEQ: cnt_d = burst_len;
            HTRANS_IDLE:   cnt_d = '0;
          endcase

          if (state_q == ARB_BURST) begin
            state_d = (cnt_d != '0) ? ARB_BURST : ARB_OWNED;
          end else if (cnt_d == '0 && !owner_locked) begin
            // Lock released outside a burst; grant moves at the next handover.
            state_d = ARB_OWNED;
          end
        end

        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // State and output registers, async reset to the parked default master.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q        <= ARB_IDLE;
      cnt_q          <= '0;
      ptr_q          <= DEF_IDX;
      hgrant_q       <= DEF_GRANT;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, regardless of statement order.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
    end
  end

  assign hgrant       = hgrant_q;
  assign hmaster      = HMASTER_WIDTH'(hmaster_q);
  assign hmaster_data = HMASTER_WIDTH'(hmaster_data_q);
  assign hmastlock    = hmastlock_q;

endmodule
